// File: rtl/spi_cmd_decoder_if.sv
// Word-level handshake between the SPI slave (master modport) and the command decoder (slave modport).
`timescale 1ns/1ps
interface spi_cmd_decoder_if #(
    parameter int DATA_SIZE = 16
);
    logic                 rx_valid;
    logic [DATA_SIZE-1:0] rx_data;
    logic                 tx_valid;
    logic [DATA_SIZE-1:0] tx_data;
    logic                 tx_ready;

    modport master (
        output rx_valid,
        output rx_data,
        output tx_ready,
        input  tx_valid,
        input  tx_data
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        input  tx_ready,
        output tx_valid,
        output tx_data
    );
endinterface

// File: rtl/spi_cmd_decoder.sv
// Parses SPI receive words into header+payload command frames, buffers WRITE data
// and streams READ/SUM/error responses back to the SPI slave transmit side.
`timescale 1ns/1ps
module spi_cmd_decoder #(
    parameter int                   DATA_SIZE  = 16,
    parameter int                   BUF_DEPTH  = 16,
    parameter int                   ADDR_WIDTH = 4,
    parameter logic [DATA_SIZE-1:0] ERR_WORD   = 16'hDEAD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cs,
    spi_cmd_decoder_if.slave bus,
    output logic             busy,
    output logic             err,
    output logic             frame_done
);

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_READ  = 4'h2;
    localparam logic [3:0] OP_SUM   = 4'h3;
    localparam logic [7:0] LP_DEPTH = 8'(BUF_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_PAYLOAD,
        S_SUM,
        S_TX_LOAD,
        S_TX_WAIT,
        S_TX_GAP
    } state_t;

    state_t               r_state;
    logic                 r_cs_meta;
    logic                 r_cs_sync;
    logic                 r_rx_vld_d;
    logic                 r_tx_rdy_d;
    logic [7:0]           r_len;
    logic [7:0]           r_idx;
    logic [DATA_SIZE-1:0] r_sum;
    logic [DATA_SIZE-1:0] r_word;
    logic                 r_single;
    logic                 r_gap;
    logic                 r_tx_valid;
    logic [DATA_SIZE-1:0] r_tx_data;
    logic                 r_busy;
    logic                 r_err;
    logic                 r_frame_done;
    logic [DATA_SIZE-1:0] r_buf [BUF_DEPTH];

    logic                 w_word_ev;
    logic                 w_rdy_rise;
    logic [3:0]           w_opcode;
    logic [7:0]           w_hdr_len;
    logic                 w_too_long;
    logic [7:0]           w_clamp_len;
    logic [7:0]           w_idx_nxt;
    logic [DATA_SIZE-1:0] w_rd_word;
    logic                 w_buf_we;

    assign w_word_ev   = bus.rx_valid & ~r_rx_vld_d;
    assign w_rdy_rise  = bus.tx_ready & ~r_tx_rdy_d;
    assign w_opcode    = bus.rx_data[DATA_SIZE-1 -: 4];
    assign w_hdr_len   = bus.rx_data[7:0];
    assign w_too_long  = (w_hdr_len > LP_DEPTH);
    assign w_clamp_len = w_too_long ? LP_DEPTH : w_hdr_len;
    assign w_idx_nxt   = r_idx + 8'd1;
    assign w_rd_word   = r_buf[r_idx[ADDR_WIDTH-1:0]];

    // Writes past the buffer end are consumed but dropped; an abort in the same cycle drops the word.
    assign w_buf_we = (r_state == S_RX_PAYLOAD) && w_word_ev && !r_cs_sync && (r_idx < LP_DEPTH);

    assign bus.tx_valid = r_tx_valid;
    assign bus.tx_data  = r_tx_data;
    assign busy         = r_busy;
    assign err          = r_err;
    assign frame_done   = r_frame_done;

    // rx_valid edge register resets high so the slave's power-up valid level is not a word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_meta  <= 1'b1;
            r_cs_sync  <= 1'b1;
            r_rx_vld_d <= 1'b1;
            r_tx_rdy_d <= 1'b1;
        end else begin
            r_cs_meta  <= cs;
            r_cs_sync  <= r_cs_meta;
            r_rx_vld_d <= bus.rx_valid;
            r_tx_rdy_d <= bus.tx_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf[r_idx[ADDR_WIDTH-1:0]] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_idx        <= '0;
            r_sum        <= '0;
            r_word       <= '0;
            r_single     <= 1'b0;
            r_gap        <= 1'b0;
            r_tx_valid   <= 1'b0;
            r_tx_data    <= '0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if ((r_state != S_IDLE) && r_cs_sync) begin
                r_state    <= S_IDLE;
                r_tx_valid <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_word_ev) begin
                            r_idx <= '0;
                            r_len <= w_clamp_len;
                            if (w_too_long) begin
                                r_err <= 1'b1;
                            end
                            case (w_opcode)
                                OP_NOP: begin
                                    r_frame_done <= 1'b1;
                                end
                                OP_WRITE: begin
                                    if (w_hdr_len == 8'd0) begin
                                        r_frame_done <= 1'b1;
                                    end else begin
                                        // WRITE keeps the full length so every payload word is consumed.
                                        r_len   <= w_hdr_len;
                                        r_state <= S_RX_PAYLOAD;
                                        r_busy  <= 1'b1;
                                    end
                                end
                                OP_READ: begin
                                    if (w_hdr_len == 8'd0) begin
                                        r_frame_done <= 1'b1;
                                    end else begin
                                        r_single <= 1'b0;
                                        r_state  <= S_TX_LOAD;
                                        r_busy   <= 1'b1;
                                    end
                                end
                                OP_SUM: begin
                                    r_sum   <= '0;
                                    r_state <= S_SUM;
                                    r_busy  <= 1'b1;
                                end
                                default: begin
                                    r_err    <= 1'b1;
                                    r_single <= 1'b1;
                                    r_word   <= ERR_WORD;
                                    r_len    <= 8'd1;
                                    r_state  <= S_TX_LOAD;
                                    r_busy   <= 1'b1;
                                end
                            endcase
                        end
                    end
                    S_RX_PAYLOAD: begin
                        if (w_word_ev) begin
                            r_idx <= w_idx_nxt;
                            if (w_idx_nxt == r_len) begin
                                r_frame_done <= 1'b1;
                                r_state      <= S_IDLE;
                                r_busy       <= 1'b0;
                            end
                        end
                    end
                    S_SUM: begin
                        if (r_idx == r_len) begin
                            r_word   <= r_sum;
                            r_single <= 1'b1;
                            r_idx    <= '0;
                            r_len    <= 8'd1;
                            r_state  <= S_TX_LOAD;
                        end else begin
                            r_sum <= r_sum + w_rd_word;
                            r_idx <= w_idx_nxt;
                        end
                    end
                    S_TX_LOAD: begin
                        r_tx_data  <= r_single ? r_word : w_rd_word;
                        r_tx_valid <= 1'b1;
                        r_state    <= S_TX_WAIT;
                    end
                    S_TX_WAIT: begin
                        if (w_rdy_rise) begin
                            r_tx_valid <= 1'b0;
                            r_idx      <= w_idx_nxt;
                            r_gap      <= 1'b0;
                            r_state    <= S_TX_GAP;
                        end
                    end
                    S_TX_GAP: begin
                        // Two idle cycles so the slave sees a fresh valid edge on the next word.
                        if (!r_gap) begin
                            r_gap <= 1'b1;
                        end else if (r_idx == r_len) begin
                            r_frame_done <= 1'b1;
                            r_state      <= S_IDLE;
                            r_busy       <= 1'b0;
                        end else begin
                            r_state <= S_TX_LOAD;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: expected response words are queued by the stimulus
// and checked by an independent monitor on every rising tx_valid.
`timescale 1ns/1ps
module tb_spi_cmd_decoder;

    logic clk = 1'b0;
    logic rst_n;
    logic cs;
    logic busy;
    logic err;
    logic frame_done;

    spi_cmd_decoder_if #(.DATA_SIZE(16)) bus ();

    spi_cmd_decoder #(
        .DATA_SIZE (16),
        .BUF_DEPTH (16),
        .ADDR_WIDTH(4),
        .ERR_WORD  (16'hDEAD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (cs),
        .bus       (bus),
        .busy      (busy),
        .err       (err),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [15:0] exp_tx[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    int          exp_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each new response word and counts frame_done pulses.
    logic        mon_prev_v = 1'b0;
    int          mon_low    = 0;
    bit          mon_in_frm = 1'b0;
    logic [15:0] mon_held   = '0;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_prev_v = 1'b0;
                mon_in_frm = 1'b0;
                mon_low    = 0;
            end else begin
                if (bus.tx_valid && !mon_prev_v) begin
                    if (mon_in_frm) check("tx_gap_ge2", 32'(mon_low >= 2), 32'd1);
                    if (exp_tx.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL tx_unexpected: got 0x%0h, expected no word", bus.tx_data);
                    end else begin
                        check("tx_data", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
                    end
                    mon_held   = bus.tx_data;
                    mon_in_frm = 1'b1;
                    mon_low    = 0;
                end else if (bus.tx_valid) begin
                    check("tx_stable", 32'(bus.tx_data), 32'(mon_held));
                end else begin
                    mon_low++;
                end
                if (frame_done) begin
                    done_cnt++;
                    mon_in_frm = 1'b0;
                end
                mon_prev_v = bus.tx_valid;
            end
        end
    end

    // Transmit-side responder: acknowledges each presented word a few cycles later.
    initial begin : responder
        bus.tx_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_valid && !bus.tx_ready) begin
                repeat (3) @(negedge clk);
                bus.tx_ready = 1'b1;
                repeat (2) @(negedge clk);
                bus.tx_ready = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_word(input logic [15:0] w, input bit exp_fd);
        bus.rx_data  = w;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        check("frame_done_timing", 32'(frame_done), 32'(exp_fd));
        if (exp_fd) exp_done++;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic check_done(input string name);
        @(negedge clk);
        check(name, 32'(done_cnt), 32'(exp_done));
    endtask

    initial begin : stimulus
        rst_n        = 1'b0;
        cs           = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);

        // rx_valid held high out of reset must not decode a frame
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("held_valid_busy", 32'(busy), 32'd0);
        check("held_valid_done", 32'(done_cnt), 32'd0);
        bus.rx_valid = 1'b0;
        cs           = 1'b0;
        repeat (4) @(negedge clk);

        // WRITE 3 words
        send_word(16'h1003, 1'b0);
        send_word(16'h1111, 1'b0);
        send_word(16'h2222, 1'b0);
        send_word(16'h3333, 1'b1);
        check("write_err", 32'(err), 32'd0);
        check("write_busy", 32'(busy), 32'd0);
        check_done("write_frames");

        // READ back 3 words
        exp_tx.push_back(16'h1111);
        exp_tx.push_back(16'h2222);
        exp_tx.push_back(16'h3333);
        send_word(16'h2003, 1'b0);
        wait_idle("read_idle");
        exp_done++;
        check_done("read_frames");
        check("read_queue_empty", 32'(exp_tx.size()), 32'd0);

        // SUM of 3 words
        exp_tx.push_back(16'h6666);
        send_word(16'h3003, 1'b0);
        wait_idle("sum_idle");
        exp_done++;
        check_done("sum_frames");

        // SUM with 16-bit wrap
        send_word(16'h1002, 1'b0);
        send_word(16'hFFFF, 1'b0);
        send_word(16'h0002, 1'b1);
        exp_tx.push_back(16'h0001);
        send_word(16'h3002, 1'b0);
        wait_idle("sum_wrap_idle");
        exp_done++;
        check_done("sum_wrap_frames");
        check("sum_err", 32'(err), 32'd0);

        // NOP and zero-length READ complete at once
        send_word(16'h0000, 1'b1);
        send_word(16'h2000, 1'b1);
        check("nop_busy", 32'(busy), 32'd0);
        check_done("nop_frames");

        // Unknown opcode
        exp_tx.push_back(16'hDEAD);
        send_word(16'h7000, 1'b0);
        wait_idle("unknown_idle");
        exp_done++;
        check_done("unknown_frames");
        check("unknown_err", 32'(err), 32'd1);

        // Reset clears the sticky error
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Oversized WRITE: 20 words consumed, first 16 stored
        send_word(16'h1014, 1'b0);
        for (int i = 0; i < 20; i++) begin
            send_word(16'h0100 + 16'(i), (i == 19));
        end
        check("long_write_err", 32'(err), 32'd1);
        check("long_write_busy", 32'(busy), 32'd0);
        check_done("long_write_frames");

        for (int i = 0; i < 16; i++) begin
            exp_tx.push_back(16'h0100 + 16'(i));
        end
        send_word(16'h2010, 1'b0);
        wait_idle("long_read_idle");
        exp_done++;
        check_done("long_read_frames");

        // cs abort mid-WRITE
        send_word(16'h1004, 1'b0);
        send_word(16'hAAAA, 1'b0);
        send_word(16'hBBBB, 1'b0);
        check("abort_busy_before", 32'(busy), 32'd1);
        cs = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_tx_valid", 32'(bus.tx_valid), 32'd0);
        check_done("abort_no_frame_done");
        cs = 1'b0;
        repeat (4) @(negedge clk);

        exp_tx.push_back(16'hAAAA);
        exp_tx.push_back(16'hBBBB);
        send_word(16'h2002, 1'b0);
        wait_idle("abort_read_idle");
        exp_done++;
        check_done("abort_read_frames");
        check("final_queue_empty", 32'(exp_tx.size()), 32'd0);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
